// File: rtl/mult32_seq_if.sv
// Request/result bundle of the 32x32 multiply sequencer, plus the borrowed adder port.
// Slave is the sequencer's view; master is the requester/adder-owner view.
interface mult32_seq_if;
  localparam int unsigned W = 32;

  logic         start;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;

  modport slave (
    input  start, sign, a, b, add_s, add_cout,
    output busy, done, hi, lo, add_a, add_b, add_cin
  );

  modport master (
    output start, sign, a, b, add_s, add_cout,
    input  busy, done, hi, lo, add_a, add_b, add_cin
  );
endinterface

// File: rtl/mult32_seq.sv
// Radix-2 shift-add 32x32 multiplier that time-shares one external 32-bit adder;
// signed operands are converted to magnitudes and the product re-negated on that same adder.
module mult32_seq (
  input logic         clk,
  input logic         rst_n,
  mult32_seq_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ABSA  = 3'd1,
    ABSB  = 3'd2,
    CALC  = 3'd3,
    NEGLO = 3'd4,
    NEGHI = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [W-1:0]  mcand, mcand_nxt;
  logic [W-1:0]  hi, hi_nxt;
  logic [W-1:0]  lo, lo_nxt;
  logic          neg, neg_nxt;
  logic          cy, cy_nxt;
  logic          sgn, sgn_nxt;
  logic          busy, done;
  logic [W-1:0]  add_a_c, add_b_c;
  logic          add_cin_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, adder drive and datapath next values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mcand_nxt = mcand;
    hi_nxt    = hi;
    lo_nxt    = lo;
    neg_nxt   = neg;
    cy_nxt    = cy;
    sgn_nxt   = sgn;
    add_a_c   = '0;
    add_b_c   = '0;
    add_cin_c = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mcand_nxt = bus.a;
          lo_nxt    = bus.b;
          hi_nxt    = '0;
          cnt_nxt   = '0;
          neg_nxt   = bus.sign & (bus.a[W-1] ^ bus.b[W-1]);
          sgn_nxt   = bus.sign;
          state_nxt = bus.sign ? ABSA : CALC;
        end
      end
      ABSA: begin
        add_a_c   = mcand[W-1] ? ~mcand : mcand;
        add_cin_c = mcand[W-1];
        mcand_nxt = bus.add_s;
        state_nxt = ABSB;
      end
      ABSB: begin
        add_a_c   = lo[W-1] ? ~lo : lo;
        add_cin_c = lo[W-1];
        lo_nxt    = bus.add_s;
        state_nxt = CALC;
      end
      CALC: begin
        // Carry-out becomes the new hi MSB; the sum LSB shifts into lo as the multiplier drains
        add_a_c = hi;
        add_b_c = lo[0] ? mcand : '0;
        hi_nxt  = {bus.add_cout, bus.add_s[W-1:1]};
        lo_nxt  = {bus.add_s[0], lo[W-1:1]};
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(W-1)) state_nxt = sgn ? NEGLO : DONE;
      end
      NEGLO: begin
        add_a_c   = neg ? ~lo : lo;
        add_cin_c = neg;
        lo_nxt    = bus.add_s;
        cy_nxt    = bus.add_cout;
        state_nxt = NEGHI;
      end
      NEGHI: begin
        add_a_c   = neg ? ~hi : hi;
        add_cin_c = neg & cy;
        hi_nxt    = bus.add_s;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      neg   <= 1'b0;
      cy    <= 1'b0;
      sgn   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      mcand <= mcand_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      neg   <= neg_nxt;
      cy    <= cy_nxt;
      sgn   <= sgn_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.hi      = hi;
  assign bus.lo      = lo;
  assign bus.add_a   = add_a_c;
  assign bus.add_b   = add_b_c;
  assign bus.add_cin = add_cin_c;
endmodule

// File: tb/tb_mult32_seq.sv
// Directed bench for mult32_seq: hand-computed products, latency, busy window,
// held-start behaviour and mid-operation reset.
module tb_mult32_seq;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  mult32_seq_if bus ();

  mult32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // External 32-bit adder
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + 33'(bus.add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Counts cycles (sampled on negedge) until done, bounded
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.busy) bcnt++;
      if (bus.done || cyc >= 100) break;
    end
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc, bcnt, lat;
    lat       = sg ? 37 : 33;
    bus.start = 1'b1;
    bus.sign  = sg;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.a = ~av;
    bus.b = ~bv;
    wait_done(cyc, bcnt);
    chk({tag, " lat"}, 64'(cyc), 64'(lat));
    chk({tag, " busy"}, 64'(bcnt), 64'(lat));
    chk({tag, " prod"}, {bus.hi, bus.lo}, {ehi, elo});
    @(negedge clk);
    chk({tag, " post"}, {62'(0), bus.busy, bus.done}, 64'(0));
    chk({tag, " hold"}, {bus.hi, bus.lo}, {ehi, elo});
  endtask

  initial begin
    int cyc, bcnt;
    n_chk     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    chk("rst status", {62'(0), bus.busy, bus.done}, 64'(0));
    chk("rst prod", {bus.hi, bus.lo}, 64'(0));
    chk("rst adder", {bus.add_a, bus.add_b}, 64'(0));
    chk("rst cin", 64'(bus.add_cin), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op("u3x5",   1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F);
    run_op("umax",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("ushift", 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    run_op("sm1x1",  1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("sminsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("szero",  1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    run_op("sm7x6",  1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("s5xm3",  1'b1, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // start held high throughout: one op per accept, operand changes while busy ignored
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    #1 bus.a = 32'd7;
    bus.b = 32'd9;
    wait_done(cyc, bcnt);
    chk("held1 lat", 64'(cyc), 64'(33));
    chk("held1 prod", {bus.hi, bus.lo}, 64'd15);
    @(negedge clk);
    chk("held gap busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    chk("held2 busy", 64'(bus.busy), 64'(1));
    bus.a = 32'd100;
    bus.b = 32'd100;
    wait_done(cyc, bcnt);
    chk("held2 lat", 64'(cyc + 1), 64'(33));
    chk("held2 prod", {bus.hi, bus.lo}, 64'd63);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held idle", {62'(0), bus.busy, bus.done}, 64'(0));

    // Reset pulse at CALC iteration 10 of an unsigned op
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid busy", 64'(bus.busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort status", {62'(0), bus.busy, bus.done}, 64'(0));
    chk("abort prod", {bus.hi, bus.lo}, 64'(0));
    chk("abort adder", {bus.add_a, bus.add_b}, 64'(0));
    chk("abort cin", 64'(bus.add_cin), 64'(0));
    @(negedge clk);
    run_op("after rst", 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
